// File: rtl/serial_frame_rcv_pkg.sv
// Shared types and defaults for the serial frame receiver.
// SERIAL_FRAME_RCV_PARITY_EN enables the PARITY state in the receiver.
package serial_frame_rcv_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_CHK = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        LOAD      = 3'd5
    } state_t;

    localparam int DEF_NUM_BITS     = 8;
    localparam int DEF_CLKS_PER_BIT = 10;

endpackage

// File: rtl/serial_frame_rcv_if.sv
// Receiver-side bundle: serial line in, parallel word + handshake + error flags out.
// SERIAL_FRAME_RCV_PARITY_EN adds the parity_error flag.
interface serial_frame_rcv_if #(
    parameter int NUM_BITS = serial_frame_rcv_pkg::DEF_NUM_BITS
);
    logic                serial_in;
    logic                data_read;
    logic [NUM_BITS-1:0] rx_data;
    logic                data_ready;
    logic                overrun_error;
    logic                framing_error;
`ifdef SERIAL_FRAME_RCV_PARITY_EN
    logic                parity_error;

    modport master (
        input  serial_in, data_read,
        output rx_data, data_ready, overrun_error, framing_error, parity_error
    );
    modport slave (
        output serial_in, data_read,
        input  rx_data, data_ready, overrun_error, framing_error, parity_error
    );
`else
    modport master (
        input  serial_in, data_read,
        output rx_data, data_ready, overrun_error, framing_error
    );
    modport slave (
        output serial_in, data_read,
        input  rx_data, data_ready, overrun_error, framing_error
    );
`endif
endinterface

// File: rtl/flex_stp_sr.sv
// Serial-to-parallel shift register; SHIFT_MSB picks which end the new bit enters.
module flex_stp_sr #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_MSB = 1'b0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                serial_in,
    output logic [NUM_BITS-1:0] parallel_out
);
    logic [NUM_BITS-1:0] shifted;

    generate
        if (SHIFT_MSB) begin : g_left
            assign shifted = {parallel_out[NUM_BITS-2:0], serial_in};
        end else begin : g_right
            assign shifted = {serial_in, parallel_out[NUM_BITS-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            parallel_out <= '1;
        else if (shift_enable)
            parallel_out <= shifted;
    end
endmodule

// File: rtl/serial_frame_rcv.sv
// Serial frame receiver: sync + start detect, mid-bit sampling, stop check, ready/read handshake.
// SERIAL_FRAME_RCV_PARITY_EN adds an even-parity bit between data and stop.
module serial_frame_rcv
    import serial_frame_rcv_pkg::*;
#(
    parameter int NUM_BITS     = DEF_NUM_BITS,
    parameter bit SHIFT_MSB    = 1'b0,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic               clk,
    input  logic               n_rst,
    serial_frame_rcv_if.master bus
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(NUM_BITS + 1);
    localparam logic [TW-1:0] HALF_LD  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LD  = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);

    logic sync1, sync2, line_prev;
    logic start_edge, tick, shift_en;

    state_t              state;
    logic [TW-1:0]       timer;
    logic [CW-1:0]       bit_cnt;
    logic [NUM_BITS-1:0] sr_q;
    logic [NUM_BITS-1:0] rx_data_q;
    logic                ready_q, overrun_q, framing_q;
`ifdef SERIAL_FRAME_RCV_PARITY_EN
    logic                parity_q;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync1     <= bus.serial_in;
            sync2     <= sync1;
            line_prev <= sync2;
        end
    end

    assign start_edge = !sync2 && line_prev;
    assign tick       = (timer == '0);
    assign shift_en   = (state == DATA) && tick;

    flex_stp_sr #(
        .NUM_BITS  (NUM_BITS),
        .SHIFT_MSB (SHIFT_MSB)
    ) u_sr (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_enable (shift_en),
        .serial_in    (sync2),
        .parallel_out (sr_q)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            rx_data_q <= '1;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
            framing_q <= 1'b0;
`ifdef SERIAL_FRAME_RCV_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            // Consumer acknowledge; a LOAD below in the same cycle overrides data_ready.
            if (bus.data_read && ready_q) begin
                ready_q   <= 1'b0;
                overrun_q <= 1'b0;
            end

            // Every sampling state runs the same free-running bit-period timer.
            if (state != IDLE && state != LOAD)
                timer <= tick ? FULL_LD : timer - 1'b1;

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        framing_q <= 1'b0;
`ifdef SERIAL_FRAME_RCV_PARITY_EN
                        parity_q  <= 1'b0;
`endif
                        timer     <= HALF_LD;
                        state     <= START_CHK;
                    end
                end
                START_CHK: begin
                    if (tick) begin
                        bit_cnt <= '0;
                        state   <= sync2 ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_FRAME_RCV_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef SERIAL_FRAME_RCV_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if ((^sr_q) ^ sync2)
                            parity_q <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (sync2) begin
                            state <= LOAD;
                        end else begin
                            framing_q <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                LOAD: begin
                    rx_data_q <= sr_q;
                    ready_q   <= 1'b1;
                    if (ready_q && !bus.data_read)
                        overrun_q <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rx_data       = rx_data_q;
    assign bus.data_ready    = ready_q;
    assign bus.overrun_error = overrun_q;
    assign bus.framing_error = framing_q;
`ifdef SERIAL_FRAME_RCV_PARITY_EN
    assign bus.parity_error  = parity_q;
`endif

endmodule

// File: doc/serial_frame_rcv.md
# serial_frame_rcv

Asynchronous-style serial frame receiver: the receive end of the team's serial link, whose transmit side is built on the parallel-to-serial shift register. It synchronizes the incoming line and detects a start bit. It samples each bit at mid-period using a clock-count timer, deserializes `NUM_BITS` data bits into a parallel word, checks the stop bit, and presents the word with a ready/read handshake and sticky error flags.

## Interface
- `NUM_BITS`, 8: data bits per frame (≥ 2).
- `SHIFT_MSB`, 0: 1 = first data bit received is the word MSB; 0 = first data bit is the LSB. Matches the transmitter's `SHIFT_MSB`.
- `CLKS_PER_BIT`, 10: clock cycles per bit period (≥ 4).
- `clk` input 1: single clock, all state on rising edge.
- `n_rst` input 1: asynchronous, active-low reset.
- `serial_in` input 1: serial line; idle-high.
- `data_read` input 1: consumer pulse acknowledging `rx_data`.
- `rx_data` output `NUM_BITS`: last good frame's data.
- `data_ready` output 1: `rx_data` holds an unread frame.
- `overrun_error` output 1: a frame was loaded while the previous one was unread.
- `framing_error` output 1: last frame's stop bit sampled 0.
- `parity_error` output 1: present only with `SERIAL_FRAME_RCV_PARITY_EN`.

## Operation
- Reset values: `rx_data` = all ones, `data_ready` = 0, `overrun_error` = 0, `framing_error` = 0, `parity_error` = 0. The synchronizer and shift register reset to all ones; the FSM resets to IDLE.
- Input conditioning: 2-flop synchronizer, then an edge flop. A start edge is a cycle T with synced line = 0 and previous = 1.
- FSM states and transitions:
  - IDLE: on start edge at T, clear `framing_error` (and `parity_error`), load the timer, go to START_CHK.
  - START_CHK: sample at T + `CLKS_PER_BIT`/2 (integer division). If sample = 1, it is a false start; return to IDLE with no flag change. If sample = 0, go to DATA.
  - DATA: sample every `CLKS_PER_BIT` cycles. Shift each sample into the shift register. Go to STOP (or PARITY) after `NUM_BITS` samples.
  - PARITY (macro only): one sample, compared against the data.
  - STOP: one sample. If 1, go to LOAD. If 0, set `framing_error`, discard the data, and return to IDLE.
  - LOAD: one cycle. Copy the shift register to `rx_data`, set `data_ready`, return to IDLE.
- Shift direction:
  - `SHIFT_MSB` = 0: shift right, new bit enters the MSB.
  - `SHIFT_MSB` = 1: shift left, new bit enters the LSB.
- Handshake:
  - `data_read` high with `data_ready` = 1 clears `data_ready` and `overrun_error` on the next edge.
  - `data_read` while `data_ready` = 0 has no effect.
- Overrun: LOAD while `data_ready` = 1 and `data_read` = 0 sets `overrun_error` and overwrites `rx_data`.
- LOAD in the same cycle as `data_read`: the load wins. `data_ready` stays 1 and `overrun_error` is not set.
- Error flags are sticky until the conditions above clear them. Flags never affect a later frame's reception.
- A start edge is recognized only in IDLE. Line activity during a frame is sampled, never re-synced.
- Reset mid-frame: immediate return to reset values. The partial frame is lost.

## Timing
- Synchronizer latency: 2 cycles from a `serial_in` change to the synced line.
- Sample instants relative to T:
  - Start: T + `CLKS_PER_BIT`/2.
  - Data bit k (k = 0..`NUM_BITS`-1): T + `CLKS_PER_BIT`/2 + (k+1)·`CLKS_PER_BIT`.
  - Stop: one bit period after the last data bit (or after parity).
- `rx_data` and `data_ready` are valid 2 cycles after the stop sample edge (STOP→LOAD, then LOAD registers).
- Back-to-back frames: IDLE is re-entered before the next start edge, with no inter-frame gap required beyond the stop bit.

## Configuration
- `SERIAL_FRAME_RCV_PARITY_EN` defined:
  - One even-parity bit follows the data bits.
  - A mismatch sets `parity_error`, yet the frame still loads normally.
  - Stop sample moves one bit period later.
- Undefined: no PARITY state, no `parity_error` port, frame = start + `NUM_BITS` + stop.

## Structure
- Package `serial_frame_rcv_pkg`:
  - State enum typedef (IDLE, START_CHK, DATA, PARITY, STOP, LOAD).
  - Default constants for `NUM_BITS` and `CLKS_PER_BIT`.
- Sub-module `flex_stp_sr` (serial-to-parallel shift register):
  - Parameters `NUM_BITS`, `SHIFT_MSB`.
  - Ports `clk`, `n_rst`, `shift_enable`, `serial_in`, `parallel_out`.
  - Resets to all ones.
- FSM, bit-period timer, bit counter and flag registers live in the top module.

## Test plan
All scenarios use `NUM_BITS`=8, `CLKS_PER_BIT`=10, `SHIFT_MSB`=0 unless noted.
- Send 0xA5 LSB-first with a good stop bit → `rx_data`=0xA5 and `data_ready`=1, 2 cycles after the stop sample; `data_read` pulse → `data_ready`=0.
- `SHIFT_MSB`=1, send bits 1,0,0,0,0,0,0,1 → `rx_data`=0x81.
- 3-cycle low glitch on an idle line → no `data_ready`, no flags, FSM back in IDLE.
- Send 0x3C with stop bit 0 → `framing_error`=1, `rx_data` unchanged; next good 0x11 → `framing_error` cleared at start, `rx_data`=0x11.
- Two frames 0x01, 0x02 with no read → `overrun_error`=1, `rx_data`=0x02; a third frame whose LOAD coincides with `data_read` → `data_ready`=1, no new overrun.
- Assert `n_rst` low mid-data-bit 4 → all outputs at reset values; the following frame 0x5A is received correctly.
